// File: rtl/dotn_acc.sv
// dotn_acc: pipelined signed dot product with a registered adder tree.
// Rows stream as first/last-framed beats and produce one result each.
module dotn_acc #(
    parameter int LANES  = 8,
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LANES*IWIDTH-1:0]        vec0,
    input  logic [LANES*IWIDTH-1:0]        vec1,
    input  logic                           ivalid,
    input  logic                           ifirst,
    input  logic                           ilast,
    output logic signed [OWIDTH-1:0]       result,
    output logic                           ovalid
);

    localparam int D  = $clog2(LANES);
    localparam int PW = 2 * IWIDTH;

    logic [LANES*IWIDTH-1:0] a_q;
    logic [LANES*IWIDTH-1:0] b_q;
    // Sideband {valid, first, last}; index 0 is S1, index D+1 meets the tree output.
    logic [2:0]              sb_q [D+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < D + 2; i++) sb_q[i] <= '0;
        end else begin
            a_q <= vec0;
            b_q <= vec1;
            sb_q[0] <= {ivalid, ifirst, ilast};
            for (int i = 1; i < D + 2; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    for (genvar k = 0; k <= D; k++) begin : g_lvl
        localparam int N = LANES >> k;
        localparam int W = PW + k;
        logic signed [W-1:0] s_q [N];

        if (k == 0) begin : g_mul
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < N; j++) s_q[j] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        s_q[j] <=
                          PW'($signed(a_q[(LANES-1-j)*IWIDTH +: IWIDTH]))
                        * PW'($signed(b_q[(LANES-1-j)*IWIDTH +: IWIDTH]));
                    end
                end
            end
        end else begin : g_add
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < N; j++) s_q[j] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        s_q[j] <= W'(g_lvl[k-1].s_q[2*j])
                                + W'(g_lvl[k-1].s_q[2*j+1]);
                    end
                end
            end
        end
    end

    logic signed [OWIDTH-1:0] sum_ext;
    logic                     beat_v;
    logic                     beat_f;
    logic                     beat_l;
    logic signed [OWIDTH-1:0] acc_q;
    logic signed [OWIDTH-1:0] acc_d;
    logic signed [OWIDTH-1:0] res_q;
    logic signed [OWIDTH-1:0] res_d;
    logic                     ov_q;
    logic                     ov_d;

    assign sum_ext = OWIDTH'(g_lvl[D].s_q[0]);
    assign beat_v  = sb_q[D+1][2];
    assign beat_f  = sb_q[D+1][1];
    assign beat_l  = sb_q[D+1][0];

    always_comb begin
        acc_d = acc_q;
        res_d = res_q;
        ov_d  = 1'b0;
        if (beat_v) begin
            acc_d = beat_f ? sum_ext : acc_q + sum_ext;
            if (beat_l) begin
                res_d = acc_d;
                ov_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            res_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
            ov_q  <= ov_d;
        end
    end

    assign result = res_q;
    assign ovalid = ov_q;

endmodule

// File: tb/tb_dotn_acc.sv
// tb_dotn_acc: directed and random beats against a row-level arithmetic model.
// Two instances share the stimulus: OWIDTH=32 and OWIDTH=20 (wrap behaviour).
module tb_dotn_acc;

    localparam int LANES = 8;
    localparam int IW    = 8;
    localparam int LAT   = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [LANES*IW-1:0]    vec0 = '0;
    logic [LANES*IW-1:0]    vec1 = '0;
    logic                   ivalid = 1'b0;
    logic                   ifirst = 1'b0;
    logic                   ilast = 1'b0;
    logic [31:0]            res32;
    logic                   ov32;
    logic [19:0]            res20;
    logic                   ov20;

    dotn_acc #(.LANES(LANES), .IWIDTH(IW), .OWIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1),
        .ivalid(ivalid), .ifirst(ifirst), .ilast(ilast),
        .result(res32), .ovalid(ov32)
    );

    dotn_acc #(.LANES(LANES), .IWIDTH(IW), .OWIDTH(20)) u_dut20 (
        .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1),
        .ivalid(ivalid), .ifirst(ifirst), .ilast(ilast),
        .result(res20), .ovalid(ov20)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] r32;
        logic [19:0] r20;
    } exp_t;

    exp_t        q[$];
    longint      acc_m = 0;
    logic [31:0] er32 = '0;
    logic [19:0] er20 = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          la[LANES];
    int          lb[LANES];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, o, e, cyc);
        end
    endtask

    function automatic longint dot();
        longint s = 0;
        for (int i = 0; i < LANES; i++) s += longint'(la[i]) * longint'(lb[i]);
        return s;
    endfunction

    task automatic fill(input int a, input int b);
        for (int i = 0; i < LANES; i++) begin
            la[i] = a;
            lb[i] = b;
        end
    endtask

    // Drive one cycle, update the row model at the edge, then check outputs.
    task automatic step(input bit r, input bit v, input bit f, input bit l);
        bit eo;
        rst    = r;
        ivalid = v;
        ifirst = f;
        ilast  = l;
        for (int i = 0; i < LANES; i++) begin
            vec0[(LANES-1-i)*IW +: IW] = 8'(la[i]);
            vec1[(LANES-1-i)*IW +: IW] = 8'(lb[i]);
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            acc_m = 0;
            q.delete();
            er32 = '0;
            er20 = '0;
        end else if (v) begin
            acc_m = f ? dot() : acc_m + dot();
            if (l) q.push_back('{cyc + LAT - 1, 32'(acc_m), 20'(acc_m)});
        end
        #1;
        eo = (q.size() > 0) && (q[0].due == cyc);
        if (eo) begin
            er32 = q[0].r32;
            er20 = q[0].r20;
            void'(q.pop_front());
        end
        chk("ovalid32", 32'(ov32), 32'(eo));
        chk("result32", res32, er32);
        chk("ovalid20", 32'(ov20), 32'(eo));
        chk("result20", 32'(res20), 32'(er20));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        fill(0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_result", res32, 32'd0);

        fill(2, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(LAT + 1);
        chk("single_48", res32, 32'd48);

        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(LAT + 1);
        chk("three_beat_144", res32, 32'd144);

        fill(-128, -128);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(LAT + 1);
        chk("neg_neg", res32, 32'd131072);

        fill(-128, 127);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(LAT + 1);
        chk("neg_pos", res32, 32'(-130048));

        la = '{1, -1, 2, -2, 3, -3, 4, -4};
        lb = '{5, 5, 5, 5, 5, 5, 5, 5};
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(LAT + 1);
        chk("per_lane_zero", res32, 32'd0);

        fill(1, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        fill(-1, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        fill(0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        fill(127, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(LAT + 1);
        chk("b2b_last_1016", res32, 32'd1016);

        fill(-128, -128);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(LAT + 1);
        chk("wrap20_zero", 32'(res20), 32'd0);
        chk("wrap32_full", res32, 32'd1048576);

        fill(2, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(LAT + 1);
        chk("reset_mid_row", res32, 32'd48);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < LANES; i++) begin
                la[i] = int'($urandom_range(255)) - 128;
                lb[i] = int'($urandom_range(255)) - 128;
            end
            step(($urandom % 64) == 0, ($urandom % 4) != 0,
                 ($urandom % 5) == 0, ($urandom % 4) == 0);
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dotn_acc.md
# dotn_acc

Parametrised, fully pipelined signed dot-product engine with multi-beat accumulation. It is the MVM engine's row-reduction unit. Each valid beat multiplies LANES pairs of signed elements, reduces them through a registered binary adder tree, and folds the sum into a running accumulator. A full row of any length streams in as consecutive beats framed by first/last markers, and the unit emits one result per row.

## Interface
- LANES, 8, number of element pairs per beat; power of two, ≥1.
- IWIDTH, 8, signed element width.
- OWIDTH, 32, signed result/accumulator width; must be ≥ 2*IWIDTH + log2(LANES).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- vec0  in  LANES*IWIDTH  packed signed operand A; lane 0 = most-significant slice, lane LANES-1 = least-significant slice.
- vec1  in  LANES*IWIDTH  packed signed operand B, same packing.
- ivalid  in  1  beat valid; accepted every cycle it is high, with no backpressure.
- ifirst  in  1  beat starts a new row; sampled only when ivalid=1.
- ilast  in  1  beat ends a row; sampled only when ivalid=1.
- result  out  OWIDTH  signed row dot product.
- ovalid  out  1  single-cycle pulse; result is valid for a new row.

## Operation
- D = log2(LANES). The pipeline stages are:
  - S1 registers vec0, vec1, ivalid, ifirst and ilast.
  - S2 forms LANES signed products, each 2*IWIDTH wide.
  - S3..S(2+D) are the adder-tree levels. Each level halves the term count and grows the width by 1 bit, with sign extension.
  - S(3+D) is the accumulate/output stage. When LANES=1 there are no tree stages.
- Sideband bits (valid, first, last) travel in a shift register alongside the data. Data registers load unconditionally. Only the valid-qualified sidebands gate the accumulator.
- At the accumulate stage, for a beat with valid=1, let the tree sum be sign-extended to OWIDTH:
  - If first=1, acc ← sum. Any prior partial is discarded.
  - If first=0, acc ← acc + sum, wrapping mod 2^OWIDTH (two's complement, no saturation).
  - If last=1, result ← the new acc value and ovalid=1 in the same cycle.
- A beat with first=1 and last=1 is a single-beat row.
- A non-first beat arriving after a completed row adds onto the held acc. Streams must open every row with ifirst.
- Beats with valid=0 leave acc, result and ovalid unchanged (ovalid=0).
- result holds its value between ovalid pulses.

## Timing
- Latency L = 3 + D cycles (L=6 at LANES=8). A last beat sampled at edge t produces ovalid=1 and the final result after edge t+L-1, i.e. visible in cycle t+L-1 relative to the sampling cycle, counting S1 as cycle 1.
- Throughput is 1 beat/cycle. Back-to-back rows are allowed with no bubble: a last beat is legally followed by a first beat on the next cycle.
- Idle cycles (ivalid=0) between beats of one row are allowed and do not break accumulation.
- Reset (rst=1 at an edge) behaviour:
  - Clears every pipeline register, sideband, acc and result to 0; ovalid=0.
  - In-flight beats are discarded; no ovalid is produced for them.
  - Inputs presented in the reset cycle are ignored.
  - The first beat sampled after rst deasserts appears after exactly L cycles.
- Simultaneous events:
  - first and last on the same beat: handled as described in Operation.
  - rst together with ivalid: rst wins.

## Test plan
- Single-beat row (LANES=8, IWIDTH=8): all lanes 2·3 with first=last=1. Expect result=48 and ovalid pulsing exactly 6 cycles after the beat; then ovalid=0 and result held at 48.
- Three-beat row: three consecutive beats of all-lanes 2·3, first on beat 1, last on beat 3, with ivalid=0 gaps of 0 and 2 cycles. Expect one ovalid, result=144, and no ovalid on beats 1–2.
- Signed extremes: all lanes −128·−128 gives 131072. Then all lanes −128·127 gives −130048. Then per-lane values (1,−1,2,−2,3,−3,4,−4)·all 5 gives 0.
- Back-to-back single-beat rows on 4 consecutive cycles with sums 8, −8, 0, 1016 (all lanes 127·1). Expect 4 consecutive ovalid cycles with results in order.
- Wrap: OWIDTH=20, eight beats of all lanes −128·−128, first on beat 1 and last on beat 8. Expect result=0 (2^20 wraps).
- Reset mid-row:
  - Sequence: first beat (sum 48); rst for 1 cycle two cycles later; then a beat with first=0, last=1, sum 48.
  - Expect no ovalid for the pre-reset beat.
  - Expect result=48, from acc cleared to 0, exactly L cycles after the post-reset beat.
